// File: rtl/pkt_buf_pkg.sv
// Shared types and default sizing for the packet-buffer ingress path.
// Holds the writer FSM state enum, the cell capacity constant and the descriptor record.
package pkt_buf_pkg;

  localparam int PKG_DATA_WIDTH    = 512;
  localparam int PKG_KEEP_WIDTH    = PKG_DATA_WIDTH / 8;
  localparam int PKG_LEN_WIDTH     = 16;
  localparam int PKG_CELL_NUM      = 64;
  localparam int PKG_CELL_ID_WIDTH = $clog2(PKG_CELL_NUM);
  localparam int PKG_CELL_BEATS    = 24;
  localparam int CELL_BYTES        = PKG_CELL_BEATS * PKG_KEEP_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    DROP,
    DROP_FREE,
    FREE,
    DESC
  } state_t;

  typedef struct packed {
    logic [PKG_CELL_ID_WIDTH-1:0] cell_id;
    logic [PKG_LEN_WIDTH-1:0]     len;
  } desc_t;

endpackage

// File: rtl/pkt_cell_writer_keep_popcount.sv
// Combinational byte count of a tkeep vector.
// Counts every set bit, so a non-contiguous mask still yields its true population.
module keep_popcount #(
  parameter int KEEP_WIDTH = 64
) (
  input  logic [KEEP_WIDTH-1:0]       i_keep,
  output logic [$clog2(KEEP_WIDTH):0] o_count
);

  localparam int CNT_W = $clog2(KEEP_WIDTH) + 1;

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      o_count = o_count + CNT_W'(i_keep[i]);
    end
  end

endmodule

// File: rtl/pkt_cell_writer.sv
// Ingress cell writer: allocates one cell per packet, writes beats to {cell, beat}, emits descriptors.
// Optional macro CELL_WR_INTENSE_DROP_EN: drop new packets instead of requesting when the pool is low.
module pkt_cell_writer
  import pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int LEN_WIDTH     = PKG_LEN_WIDTH,
  parameter int CELL_NUM      = PKG_CELL_NUM,
  parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
  parameter int CELL_BEATS    = PKG_CELL_BEATS,
  parameter int BEAT_WIDTH    = $clog2(CELL_BEATS)
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,

  output logic                            alloc_mem_req,
  output logic [LEN_WIDTH-1:0]            alloc_mem_size,
  input  logic [CELL_ID_WIDTH-1:0]        alloc_cell_id,
  input  logic                            alloc_mem_success,
  input  logic                            alloc_mem_intense,

  output logic                            free_mem_req,
  input  logic                            free_mem_ready,
  output logic [LEN_WIDTH-1:0]            free_mem_size,
  output logic [CELL_ID_WIDTH-1:0]        free_cell_id,

  output logic                            mem_wr_en,
  output logic [CELL_ID_WIDTH+BEAT_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]           mem_wr_data,

  output logic                            m_desc_valid,
  input  logic                            m_desc_ready,
  output logic [CELL_ID_WIDTH-1:0]        m_desc_cell_id,
  output logic [LEN_WIDTH-1:0]            m_desc_len,

  output logic [31:0]                     drop_count
);

  localparam int CNT_W = $clog2(KEEP_WIDTH) + 1;
  // One extra index bit so the "cell full" value CELL_BEATS is representable for any depth.
  localparam int IDX_W = BEAT_WIDTH + 1;
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(CELL_BEATS);

  state_t                   r_state;
  state_t                   w_next;
  logic [CELL_ID_WIDTH-1:0] r_cell;
  logic [IDX_W-1:0]         r_beat;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [31:0]              r_drop;

  logic [CNT_W-1:0]         w_pop;
  logic                     w_intense;
  logic                     w_req;
  logic                     w_grant;
  logic                     w_full;
  logic                     w_drop_inc;

  keep_popcount #(
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_keep_popcount (
    .i_keep (s_axis_tkeep),
    .o_count(w_pop)
  );

`ifdef CELL_WR_INTENSE_DROP_EN
  assign w_intense = alloc_mem_intense;
`else
  logic w_unused_intense;
  assign w_intense        = 1'b0;
  assign w_unused_intense = alloc_mem_intense;
`endif

  assign w_full     = (r_beat == FULL_IDX);
  assign w_req      = !rst && (r_state == IDLE) && s_axis_tvalid && !w_intense;
  assign w_grant    = w_req && alloc_mem_success;
  assign w_drop_inc = !rst && s_axis_tvalid &&
                      (((r_state == IDLE) && !w_grant) || ((r_state == WRITE) && w_full));

  assign alloc_mem_size = LEN_WIDTH'(CELL_BEATS * KEEP_WIDTH);
  assign mem_wr_data    = s_axis_tdata;
  assign m_desc_cell_id = r_cell;
  assign m_desc_len     = r_len;
  assign free_cell_id   = r_cell;
  assign free_mem_size  = r_len;
  assign drop_count     = r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (s_axis_tvalid) begin
          if (w_grant) begin
            w_next = s_axis_tlast ? DESC : WRITE;
          end else begin
            w_next = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      WRITE: begin
        if (s_axis_tvalid) begin
          if (w_full) begin
            w_next = s_axis_tlast ? FREE : DROP_FREE;
          end else if (s_axis_tlast) begin
            w_next = DESC;
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          w_next = IDLE;
        end
      end
      DROP_FREE: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          w_next = FREE;
        end
      end
      FREE: begin
        if (free_mem_ready) begin
          w_next = IDLE;
        end
      end
      DESC: begin
        if (m_desc_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high so no beat or request leaks through the reset cycle.
  always_comb begin
    s_axis_tready = 1'b0;
    alloc_mem_req = w_req;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = {r_cell, r_beat[BEAT_WIDTH-1:0]};
    free_mem_req  = 1'b0;
    m_desc_valid  = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          s_axis_tready = s_axis_tvalid;
          mem_wr_en     = w_grant;
          mem_wr_addr   = {alloc_cell_id, {BEAT_WIDTH{1'b0}}};
        end
        WRITE: begin
          s_axis_tready = 1'b1;
          mem_wr_en     = s_axis_tvalid && !w_full;
        end
        DROP, DROP_FREE: begin
          s_axis_tready = 1'b1;
        end
        FREE: begin
          free_mem_req = 1'b1;
        end
        DESC: begin
          m_desc_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cell <= '0;
      r_beat <= '0;
      r_len  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cell <= alloc_cell_id;
            r_beat <= IDX_W'(1);
            r_len  <= LEN_WIDTH'(w_pop);
          end
        end
        WRITE: begin
          if (s_axis_tvalid && !w_full) begin
            r_beat <= r_beat + IDX_W'(1);
            r_len  <= r_len + LEN_WIDTH'(w_pop);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop_inc && (r_drop != '1)) begin
      r_drop <= r_drop + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_cell_writer.sv
// Self-checking bench for pkt_cell_writer: directed vector table, randomized packets
// against a packet-level reference model, and hand sequences for back-to-back and reset.
module tb_pkt_cell_writer;
  import pkt_buf_pkg::*;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int LW  = 16;
  localparam int CIW = 6;
  localparam int CB  = 24;
  localparam int BW  = 5;
  localparam int AW  = CIW + BW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic [KW-1:0]  s_axis_tkeep = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic           alloc_mem_req;
  logic [LW-1:0]  alloc_mem_size;
  logic [CIW-1:0] alloc_cell_id = '0;
  logic           alloc_mem_success = 1'b0;
  logic           alloc_mem_intense = 1'b0;
  logic           free_mem_req;
  logic           free_mem_ready = 1'b0;
  logic [LW-1:0]  free_mem_size;
  logic [CIW-1:0] free_cell_id;
  logic           mem_wr_en;
  logic [AW-1:0]  mem_wr_addr;
  logic [DW-1:0]  mem_wr_data;
  logic           m_desc_valid;
  logic           m_desc_ready = 1'b0;
  logic [CIW-1:0] m_desc_cell_id;
  logic [LW-1:0]  m_desc_len;
  logic [31:0]    drop_count;

  pkt_cell_writer #(
    .DATA_WIDTH   (DW),
    .KEEP_WIDTH   (KW),
    .LEN_WIDTH    (LW),
    .CELL_NUM     (64),
    .CELL_ID_WIDTH(CIW),
    .CELL_BEATS   (CB),
    .BEAT_WIDTH   (BW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .alloc_mem_req    (alloc_mem_req),
    .alloc_mem_size   (alloc_mem_size),
    .alloc_cell_id    (alloc_cell_id),
    .alloc_mem_success(alloc_mem_success),
    .alloc_mem_intense(alloc_mem_intense),
    .free_mem_req     (free_mem_req),
    .free_mem_ready   (free_mem_ready),
    .free_mem_size    (free_mem_size),
    .free_cell_id     (free_cell_id),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .m_desc_valid     (m_desc_valid),
    .m_desc_ready     (m_desc_ready),
    .m_desc_cell_id   (m_desc_cell_id),
    .m_desc_len       (m_desc_len),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observed traffic, captured mid-cycle where all combinational outputs are settled.
  logic [AW-1:0] q_wa[$];
  logic [31:0]   q_wd[$];
  desc_t         q_desc[$];
  desc_t         q_free[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        q_wa.push_back(mem_wr_addr);
        q_wd.push_back(mem_wr_data[31:0]);
      end
      if (m_desc_valid && m_desc_ready) q_desc.push_back('{m_desc_cell_id, m_desc_len});
      if (free_mem_req && free_mem_ready) q_free.push_back('{free_cell_id, free_mem_size});
    end
  end

  int     kc[0:31];
  int     pkt_no  = 0;
  longint exp_drop = 0;

  function automatic logic [KW-1:0] keep_mask(input int c);
    logic [KW-1:0] m;
    m = '0;
    for (int j = 0; j < KW; j++) if (j < c) m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] beat_tag(input int pn, input int b);
    return {pn[15:0], b[15:0]};
  endfunction

  // Entered and left at posedge+1. lat = cycles from end of packet to desc/free valid, -1 if none.
  task automatic send_pkt(input int n, input bit grant, input logic [CIW-1:0] id,
                          input int hold, output int lat);
    bit ok;
    logic           s_dv, s_fv;
    logic [CIW-1:0] s_did, s_fid;
    logic [LW-1:0]  s_dlen, s_flen;
    q_wa.delete(); q_wd.delete(); q_desc.delete(); q_free.delete();
    alloc_mem_success = grant;
    alloc_cell_id     = id;
    for (int b = 0; b < n; b++) begin
      s_axis_tdata  = {16{beat_tag(pkt_no, b)}};
      s_axis_tkeep  = keep_mask(kc[b]);
      s_axis_tlast  = (b == n - 1);
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
        @(negedge clk);
        if (s_axis_tready) ok = 1'b1;
      end
      if (!ok) chk($sformatf("p%0d_beat%0d_accept", pkt_no, b), 0, 1);
      @(posedge clk); #1;
    end
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    alloc_mem_success = 1'b0;
    lat = -1;
    for (int w = 0; w < 4 && lat < 0; w++) begin
      @(negedge clk);
      if (m_desc_valid || free_mem_req) lat = w;
    end
    if (lat >= 0) begin
      s_dv = m_desc_valid; s_did = m_desc_cell_id; s_dlen = m_desc_len;
      s_fv = free_mem_req; s_fid = free_cell_id;   s_flen = free_mem_size;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk($sformatf("p%0d_hold_desc_valid", pkt_no), m_desc_valid, s_dv);
        chk($sformatf("p%0d_hold_desc_id", pkt_no), m_desc_cell_id, s_did);
        chk($sformatf("p%0d_hold_desc_len", pkt_no), m_desc_len, s_dlen);
        chk($sformatf("p%0d_hold_free_req", pkt_no), free_mem_req, s_fv);
        chk($sformatf("p%0d_hold_free_id", pkt_no), free_cell_id, s_fid);
        chk($sformatf("p%0d_hold_free_size", pkt_no), free_mem_size, s_flen);
        chk($sformatf("p%0d_hold_tready", pkt_no), s_axis_tready, 0);
      end
      @(posedge clk); #1;
      m_desc_ready   = 1'b1;
      free_mem_ready = 1'b1;
      @(posedge clk); #1;
      m_desc_ready   = 1'b0;
      free_mem_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_pkt(input string tg, input int pn, input logic [CIW-1:0] id,
                           input int exp_wr, input int exp_len, input bit exp_desc,
                           input bit exp_free, input int drop_inc, input int lat);
    exp_drop += drop_inc;
    chk({tg, "_wr_count"}, q_wa.size(), exp_wr);
    for (int i = 0; i < q_wa.size() && i < exp_wr; i++) begin
      chk($sformatf("%s_wr_addr%0d", tg, i), q_wa[i], longint'(id) * 32 + i);
      chk($sformatf("%s_wr_data%0d", tg, i), q_wd[i], beat_tag(pn, i));
    end
    chk({tg, "_desc_count"}, q_desc.size(), exp_desc ? 1 : 0);
    if (exp_desc && q_desc.size() == 1) begin
      chk({tg, "_desc_id"}, q_desc[0].cell_id, id);
      chk({tg, "_desc_len"}, q_desc[0].len, exp_len);
    end
    chk({tg, "_free_count"}, q_free.size(), exp_free ? 1 : 0);
    if (exp_free && q_free.size() == 1) begin
      chk({tg, "_free_id"}, q_free[0].cell_id, id);
      chk({tg, "_free_size"}, q_free[0].len, exp_len);
    end
    chk({tg, "_drop_count"}, drop_count, exp_drop);
    if (exp_desc || exp_free) chk({tg, "_latency"}, lat, 0);
  endtask

  typedef struct {
    int             n;
    int             keep_mode;  // 0 full, 1 full with 4-byte last beat, 2 all zero
    bit             grant;
    logic [CIW-1:0] id;
    int             hold;
    int             exp_len;
    int             exp_wr;
    bit             exp_desc;
    bit             exp_free;
    int             exp_drop_inc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int n, nw, len;
    bit g;
    logic [CIW-1:0] id;

    vecs[0] = '{3,  0, 1'b1, 6'd5,  0, 192,  3,  1'b1, 1'b0, 0};
    vecs[1] = '{1,  1, 1'b1, 6'd0,  5, 4,    1,  1'b1, 1'b0, 0};
    vecs[2] = '{4,  0, 1'b0, 6'd2,  0, 0,    0,  1'b0, 1'b0, 1};
    vecs[3] = '{26, 0, 1'b1, 6'd9,  3, 1536, 24, 1'b0, 1'b1, 1};
    vecs[4] = '{24, 0, 1'b1, 6'd12, 0, 1536, 24, 1'b1, 1'b0, 0};
    vecs[5] = '{25, 0, 1'b1, 6'd3,  1, 1536, 24, 1'b0, 1'b1, 1};
    vecs[6] = '{2,  2, 1'b1, 6'd63, 0, 0,    2,  1'b1, 1'b0, 0};
    vecs[7] = '{1,  0, 1'b0, 6'd1,  0, 0,    0,  1'b0, 1'b0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_alloc_req", alloc_mem_req, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_desc_valid", m_desc_valid, 0);
    chk("rst_free_req", free_mem_req, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("alloc_size", alloc_mem_size, CB * KW);
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[v]) begin
      for (int b = 0; b < 32; b++) begin
        kc[b] = (vecs[v].keep_mode == 2) ? 0 : KW;
        if (vecs[v].keep_mode == 1 && b == vecs[v].n - 1) kc[b] = 4;
      end
      send_pkt(vecs[v].n, vecs[v].grant, vecs[v].id, vecs[v].hold, lat);
      check_pkt($sformatf("vec%0d", v), pkt_no, vecs[v].id, vecs[v].exp_wr, vecs[v].exp_len,
                vecs[v].exp_desc, vecs[v].exp_free, vecs[v].exp_drop_inc, lat);
      pkt_no++;
    end

    // Randomized packets against the packet-level model
    for (int r = 0; r < 40; r++) begin
      n  = $urandom_range(1, 28);
      g  = ($urandom_range(0, 3) != 0);
      id = CIW'($urandom_range(0, 63));
      alloc_mem_intense = 1'($urandom_range(0, 1));
      for (int b = 0; b < 32; b++) kc[b] = $urandom_range(0, KW);
      nw  = g ? ((n < CB) ? n : CB) : 0;
      len = 0;
      for (int b = 0; b < nw; b++) len += kc[b];
      send_pkt(n, g, id, $urandom_range(0, 2), lat);
      check_pkt($sformatf("rnd%0d", r), pkt_no, id, nw, len, g && (n <= CB), g && (n > CB),
                (!g || n > CB) ? 1 : 0, lat);
      pkt_no++;
    end
    alloc_mem_intense = 1'b0;

    // Back-to-back: next request only after the descriptor handshake
    q_wa.delete(); q_desc.delete();
    m_desc_ready = 1'b1; alloc_mem_success = 1'b1; alloc_cell_id = 6'd20;
    s_axis_tkeep = '1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    s_axis_tlast = 1'b1;
    @(posedge clk); #1;
    alloc_cell_id = 6'd21; s_axis_tkeep = keep_mask(4); s_axis_tlast = 1'b1;
    @(negedge clk);
    chk("b2b_req_in_desc", alloc_mem_req, 0);
    chk("b2b_tready_in_desc", s_axis_tready, 0);
    chk("b2b_desc_valid_a", m_desc_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_req_after_hs", alloc_mem_req, 1);
    chk("b2b_desc_valid_gap", m_desc_valid, 0);
    chk("b2b_wr_addr_b", mem_wr_addr, 21 * 32);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; alloc_mem_success = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    m_desc_ready = 1'b0;
    chk("b2b_desc_count", q_desc.size(), 2);
    if (q_desc.size() == 2) begin
      chk("b2b_desc_a", q_desc[0], {6'd20, 16'd128});
      chk("b2b_desc_b", q_desc[1], {6'd21, 16'd4});
    end
    chk("b2b_wr_count", q_wa.size(), 3);

    // Reset while in WRITE
    alloc_mem_success = 1'b1; alloc_cell_id = 6'd7;
    s_axis_tkeep = '1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; alloc_mem_success = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("wrst_tready", s_axis_tready, 0);
    chk("wrst_alloc_req", alloc_mem_req, 0);
    chk("wrst_wr_en", mem_wr_en, 0);
    chk("wrst_desc_valid", m_desc_valid, 0);
    chk("wrst_free_req", free_mem_req, 0);
    chk("wrst_drop_count", drop_count, 0);
    chk("wrst_desc_len", m_desc_len, 0);
    exp_drop = 0;
    @(posedge clk); #1;
    for (int b = 0; b < 32; b++) kc[b] = KW;
    send_pkt(2, 1'b1, 6'd4, 0, lat);
    check_pkt("post_rst", pkt_no, 6'd4, 2, 128, 1'b1, 1'b0, 0, lat);
    pkt_no++;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/pkt_cell_writer.md
Name: pkt_cell_writer

Overview:
- Ingress stage directly upstream of the cell allocator.
- Takes an AXI-Stream packet, requests one cell from the allocator on the first beat, and writes the beats into cell memory at {cell_id, beat_idx}.
- On tlast it emits a descriptor (cell_id, byte length) to the PIFO/scheduler.
- Packets that get no cell are dropped. Packets that overflow their cell are dropped and their cell is returned through a free port.

Parameters:
- DATA_WIDTH, 512, stream/memory data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- LEN_WIDTH, 16, byte-length width; must match the allocator.
- CELL_NUM, 64, number of cells.
- CELL_ID_WIDTH, $clog2(CELL_NUM), cell index width.
- CELL_BEATS, 24, beats per cell (1536 B at 512 b).
- BEAT_WIDTH, $clog2(CELL_BEATS), beat index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  packet data.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables; contiguous from LSB.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted.
- s_axis_tlast  in  1  last beat of packet.
- alloc_mem_req  out  1  cell request.
- alloc_mem_size  out  LEN_WIDTH  constant CELL_BEATS*KEEP_WIDTH.
- alloc_cell_id  in  CELL_ID_WIDTH  granted cell.
- alloc_mem_success  in  1  grant; combinational, same cycle as req.
- alloc_mem_intense  in  1  free pool low.
- free_mem_req  out  1  return cell.
- free_mem_ready  in  1  free port accepted.
- free_mem_size  out  LEN_WIDTH  bytes written before overflow.
- free_cell_id  out  CELL_ID_WIDTH  cell being returned.
- mem_wr_en  out  1  cell memory write strobe.
- mem_wr_addr  out  CELL_ID_WIDTH+BEAT_WIDTH  {cell_id, beat_idx}.
- mem_wr_data  out  DATA_WIDTH  beat data.
- m_desc_valid  out  1  descriptor valid.
- m_desc_ready  in  1  descriptor accepted.
- m_desc_cell_id  out  CELL_ID_WIDTH  packet cell.
- m_desc_len  out  LEN_WIDTH  packet byte length.
- drop_count  out  32  total dropped packets; saturating.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, all valid/req/en outputs 0, drop_count 0, beat_idx 0, length 0.
- State IDLE:
  - alloc_mem_req = s_axis_tvalid, combinational.
  - s_axis_tready = alloc_mem_success, or 1 when s_axis_tvalid && !alloc_mem_success (drop path).
  - On success: latch alloc_cell_id and write beat 0 (mem_wr_en=1, addr {id,0}) in the same cycle; len = popcount(tkeep).
  - Then: tlast -> DESC, else -> WRITE.
  - On no success: drop_count++; tlast -> stay IDLE, else -> DROP.
- State WRITE:
  - s_axis_tready=1.
  - Each accepted beat: beat_idx++ and writes {cell, beat_idx}; len += popcount(tkeep).
  - tlast -> DESC.
  - A beat arriving with beat_idx==CELL_BEATS is not written; it enters overflow: drop_count++, tlast -> FREE, else -> DROP_FREE.
- State DROP: tready=1, discard beats; tlast -> IDLE.
- State DROP_FREE: tready=1, discard beats; tlast -> FREE.
- State FREE:
  - tready=0.
  - free_mem_req=1 with the latched cell id and len, held stable until free_mem_ready, then -> IDLE.
- State DESC:
  - tready=0.
  - m_desc_valid=1 with registered cell_id and len, held stable until m_desc_ready, then -> IDLE. Next-packet allocation starts the cycle after.
- Latency: descriptor valid 1 cycle after tlast accepted. Memory write uses the same cycle as beat acceptance.
- len arithmetic: LEN_WIDTH unsigned; cannot wrap because it is bounded by the CELL_BEATS*KEEP_WIDTH cell capacity.
- Exactly CELL_BEATS beats with tlast on the last is legal, not an overflow.
- tkeep==0 beats count 0 bytes but are still written.
- Reset mid-packet: state IDLE. Any held cell is leaked (allocator reset accompanies it). Any remaining input beats are treated as a new packet.

Optional Feature:
- Macro CELL_WR_INTENSE_DROP_EN.
- When defined: in IDLE, if alloc_mem_intense=1 no request is issued (alloc_mem_req=0). The packet takes the drop path and drop_count increments.
- When undefined: alloc_mem_intense is ignored.

Decomposition:
- Shared package pkt_buf_pkg: state enum (IDLE, WRITE, DROP, DROP_FREE, FREE, DESC), CELL_BYTES constant, descriptor struct {cell_id, len}.
- One sub-module: keep_popcount (combinational tkeep -> byte count, $clog2(KEEP_WIDTH)+1 bits).

Test Plan:
- 3-beat packet, full tkeep, success with id 5:
  - writes at addr 5*2^BEAT_WIDTH+0..2;
  - descriptor {5, 192} one cycle after tlast.
- 1-beat packet, tkeep=0x0F, id 0: immediate DESC {0, 4}; hold m_desc_ready=0 for 5 cycles -> valid and data stable, tready=0.
- alloc_mem_success=0 for a 4-beat packet: no mem_wr_en, all 4 beats accepted, drop_count=1, no descriptor.
- 26-beat packet, CELL_BEATS=24, id 9:
  - 24 writes, no write for beats 25-26;
  - free_mem_req with {9, 1536} held until ready;
  - drop_count=1.
- Back-to-back packets with m_desc_ready=1: the second packet's alloc_mem_req rises the cycle after the first descriptor handshake.
- rst asserted in WRITE: next cycle all outputs 0, state IDLE; the following packet allocates normally.
